dequantizer: RTL
================

# dequantizer

Streaming dequantizer for the NPU datapath: the inverse of the accumulator-to-int8 quantizer. It accepts a packed word of N signed int8 activations/weights plus per-word scale, zero-point and shift. It emits one sign-correct, saturated ACC_WIDTH value per lane, serially, lane 0 first. It sits between the int8 operand buffers and any consumer that operates at accumulator precision, such as the bias add and residual add.

## Interface
- N, 4: lanes per packed input word
- DATA_WIDTH, `DATA_WIDTH (8): signed input element width
- ACC_WIDTH, `ACC_WIDTH (16): signed output width
- SCALE_WIDTH, 8: unsigned scale width
- SHIFT_WIDTH, $clog2(ACC_WIDTH): right-shift amount width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  packed word and config valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  N*DATA_WIDTH  packed signed elements, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_scale  in  SCALE_WIDTH  unsigned multiplier
- in_zero  in  DATA_WIDTH  signed zero-point
- in_shift  in  SHIFT_WIDTH  arithmetic right shift, rounded
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer takes result this cycle
- out_data  out  ACC_WIDTH  signed dequantized value
- out_last  out  1  out_data is lane N-1 of its word
- out_sat  out  1  out_data was clamped

## Operation
- Word transfer: in_valid && in_ready at a rising edge. Result transfer: out_valid && out_ready at a rising edge.
- FSM has two states:
  - IDLE: no word held.
  - BUSY: word held, lanes pending or presenting.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). It is combinational from out_ready, which gives back-to-back words with no bubble.
- On word accept:
  - latch in_data, in_scale, in_zero, in_shift
  - load output register with lane 0 result
  - lane pointer <= 1
  - state <= BUSY
- On result transfer with lane pointer < N: load lane[pointer] result, pointer++.
- On transfer of out_last:
  - if a word is accepted in the same edge, its lane 0 is loaded
  - otherwise out_valid <= 0 and state <= IDLE
- Holding: while out_valid && !out_ready, out_data, out_last and out_sat stay stable. The latched word and config are unaffected by the in_* pins.
- Arithmetic per lane, all signed and full precision, never truncated before saturation:
  - d = q - in_zero, DATA_WIDTH+1 bits
  - p = d * in_scale, with scale zero-extended
  - r = (p + (shift ? 1 << (shift-1) : 0)) >>> shift, i.e. round half toward +inf
  - out_data = clamp(r, -2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1)
  - out_sat = 1 iff a clamp occurred
- Identity config (scale=1, zero=0, shift=0) is exact sign extension.
- in_shift ≥ bit width of p yields 0 for p ≥ 0 and -1 for p < 0 (rounding term included); the block must not produce X.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, out_data=0, out_last=0, out_sat=0, pointer=0. in_ready=1 whenever state is IDLE.
- Reset mid-word discards all pending lanes; the first post-reset output comes only from a new word.
- Latency: word accepted at edge k; lane 0 is valid after edge k; lane i is valid after edge k+i with out_ready held high.
- Throughput: one result per cycle sustained; N cycles per word; no idle cycle between words when in_valid is held.
- out_valid never drops without a transfer. out_last is asserted only with out_valid.
- Simultaneous last-lane transfer and new-word accept is legal and required (see Operation).
- in_valid asserted in BUSY before the last-lane transfer is held off: in_ready=0 and nothing is latched.

## Test plan
- Identity config, in_data=0xD6_80_7F_42, out_ready=1 -> 0x0042, 0x007F, 0xFF80, 0xFFD6 on consecutive cycles; out_last only on the 4th; out_sat=0 throughout.
- Saturation high: lane 0x7F, zero=0x80, scale=255, shift=0 -> 32767 with out_sat=1. Saturation low: lane 0x80, zero=0x7F, scale=255, shift=0 -> -32768 with out_sat=1.
- Rounding with scale=10, zero=0, shift=1: lanes 0xFD, 0x03 -> -15 (0xFFF1) and 15 (0x000F). Rounding with scale=1, shift=2: lane 0x06 -> 2.
- Backpressure: toggle out_ready randomly across two words held valid back to back -> 8 results in order, outputs stable while stalled, in_ready high only on the last-lane transfer edge, zero-gap handover.
- Config isolation: change in_scale/in_zero/in_data during BUSY -> remaining lanes use the latched values.
- Reset mid-word: assert rst_n=0 after lane 1 -> out_valid=0 and out_data=0 immediately (asynchronous); a subsequent word starts again at lane 0.

Source files
------------

// File: rtl/dequantizer_if.sv
// Handshake/payload bundle between the int8 operand buffers and the dequantizer,
// plus the dequantizer's result stream towards accumulator-precision consumers.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

interface dequantizer_if #(
    parameter int unsigned N           = 4,
    parameter int unsigned DATA_WIDTH  = `DATA_WIDTH,
    parameter int unsigned ACC_WIDTH   = `ACC_WIDTH,
    parameter int unsigned SCALE_WIDTH = 8,
    parameter int unsigned SHIFT_WIDTH = $clog2(ACC_WIDTH)
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N*DATA_WIDTH-1:0]   in_data;
    logic [SCALE_WIDTH-1:0]    in_scale;
    logic [DATA_WIDTH-1:0]     in_zero;
    logic [SHIFT_WIDTH-1:0]    in_shift;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_WIDTH-1:0]      out_data;
    logic                      out_last;
    logic                      out_sat;

    modport slave (
        input  in_valid, in_data, in_scale, in_zero, in_shift, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat
    );

    modport master (
        output in_valid, in_data, in_scale, in_zero, in_shift, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat
    );
endinterface

// File: rtl/dequantizer.sv
// Streaming int8 -> accumulator-precision dequantizer: (q - zero) * scale, rounded
// arithmetic right shift, saturate; one lane per cycle, lane 0 first.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

module dequantizer #(
    parameter int unsigned N           = 4,
    parameter int unsigned DATA_WIDTH  = `DATA_WIDTH,
    parameter int unsigned ACC_WIDTH   = `ACC_WIDTH,
    parameter int unsigned SCALE_WIDTH = 8,
    parameter int unsigned SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
    input logic         clk,
    input logic         rst_n,
    dequantizer_if.slave bus
);
    localparam int unsigned DW1   = DATA_WIDTH + 1;
    localparam int unsigned PW    = DW1 + SCALE_WIDTH + 1;
    localparam int unsigned RW    = (PW + 1 > ACC_WIDTH + 1) ? PW + 1 : ACC_WIDTH + 1;
    localparam int unsigned PTR_W = $clog2(N + 1);

    localparam logic signed [RW-1:0] ACC_MAX = {{(RW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] ACC_MIN = {{(RW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, BUSY} state_t;

    // Full-precision lane result; returns {sat, value}. Wide enough that no shift amount loses sign.
    function automatic logic [ACC_WIDTH:0] lane_calc(
        input logic [DATA_WIDTH-1:0]  q,
        input logic [DATA_WIDTH-1:0]  zero,
        input logic [SCALE_WIDTH-1:0] scale,
        input logic [SHIFT_WIDTH-1:0] shift
    );
        logic signed [DW1-1:0] d;
        logic signed [PW-1:0]  p;
        logic signed [RW-1:0]  rnd;
        logic signed [RW-1:0]  r;
        d   = $signed({q[DATA_WIDTH-1], q}) - $signed({zero[DATA_WIDTH-1], zero});
        p   = PW'(d) * $signed(PW'({1'b0, scale}));
        rnd = '0;
        if (shift != '0)
            rnd = RW'(1) << (shift - SHIFT_WIDTH'(1));
        r   = (RW'(p) + rnd) >>> shift;
        if (r > ACC_MAX)
            return {1'b1, ACC_MAX[ACC_WIDTH-1:0]};
        if (r < ACC_MIN)
            return {1'b1, ACC_MIN[ACC_WIDTH-1:0]};
        return {1'b0, r[ACC_WIDTH-1:0]};
    endfunction

    state_t                  state;
    logic [PTR_W-1:0]        ptr;
    logic [N*DATA_WIDTH-1:0] word_q;
    logic [SCALE_WIDTH-1:0]  scale_q;
    logic [DATA_WIDTH-1:0]   zero_q;
    logic [SHIFT_WIDTH-1:0]  shift_q;
    logic                    valid_q;
    logic [ACC_WIDTH-1:0]    data_q;
    logic                    last_q;
    logic                    sat_q;

    logic [DATA_WIDTH-1:0]   lane_c;
    logic [ACC_WIDTH:0]      first_res_c;
    logic [ACC_WIDTH:0]      next_res_c;
    logic                    xfer_c;
    logic                    ready_c;
    logic                    accept_c;

    always_comb begin
        lane_c = '0;
        for (int i = 0; i < N; i++)
            if (ptr == PTR_W'(i))
                lane_c = word_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign first_res_c = lane_calc(bus.in_data[DATA_WIDTH-1:0], bus.in_zero, bus.in_scale, bus.in_shift);
    assign next_res_c  = lane_calc(lane_c, zero_q, scale_q, shift_q);
    assign xfer_c      = valid_q && bus.out_ready;
    // Ready is combinational from out_ready so a new word lands on the last-lane edge.
    assign ready_c     = (state == IDLE) || (xfer_c && last_q);
    assign accept_c    = bus.in_valid && ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            word_q  <= '0;
            scale_q <= '0;
            zero_q  <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else if (accept_c) begin
            state   <= BUSY;
            word_q  <= bus.in_data;
            scale_q <= bus.in_scale;
            zero_q  <= bus.in_zero;
            shift_q <= bus.in_shift;
            valid_q <= 1'b1;
            data_q  <= first_res_c[ACC_WIDTH-1:0];
            sat_q   <= first_res_c[ACC_WIDTH];
            last_q  <= (N == 1);
            ptr     <= PTR_W'(1);
        end else if (state == BUSY && xfer_c) begin
            if (last_q) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                ptr     <= '0;
            end else begin
                data_q  <= next_res_c[ACC_WIDTH-1:0];
                sat_q   <= next_res_c[ACC_WIDTH];
                last_q  <= (ptr == PTR_W'(N - 1));
                ptr     <= ptr + PTR_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.out_sat   = sat_q;
endmodule
